// File: rtl/calc_pkg.sv
// Shared definitions for the calculator keypad front end: key codes, the
// entry phase encoding, the idle operation code and a decimal digit counter.
package calc_pkg;

    localparam int unsigned KEY_W = 4;
    localparam int unsigned CNT_W = 2;

    localparam logic [KEY_W-1:0] KEY_ADD = 4'd10;
    localparam logic [KEY_W-1:0] KEY_SUB = 4'd11;
    localparam logic [KEY_W-1:0] KEY_MUL = 4'd12;
    localparam logic [KEY_W-1:0] KEY_CLR = 4'd13;
    localparam logic [KEY_W-1:0] KEY_EQ  = 4'd14;
    localparam logic [KEY_W-1:0] KEY_BS  = 4'd15;

    localparam logic [KEY_W-1:0] OP_IDLE = 4'd13;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        SHOW    = 2'd2
    } phase_t;

    // Number of decimal digits needed to print v (0 for v == 0).
    function automatic logic [CNT_W-1:0] num_digits(input int unsigned v);
        int unsigned rem;
        int unsigned n;
        rem = v;
        n   = 0;
        for (int i = 0; i < 10; i++) begin
            if (rem != 0) begin
                n   = n + 1;
                rem = rem / 10;
            end
        end
        return CNT_W'(n);
    endfunction

endpackage

// File: rtl/calc_digit_accum.sv
// Decimal operand accumulator: holds one operand and its digit count.
// Controls (priority order): clr, load (value=digit, count=1), push (shift in
// a decimal digit while below MAX_DIGITS), and with CALC_BACKSPACE_EN also
// pop (drop last digit) and recount (count = decimal digits of value).
// Ports: clk, rst, clr, load, push, [pop, recount], digit, value, cnt, cnt_nxt.
// cnt_nxt exposes the next-state count so the parent can register it.
module calc_digit_accum
    import calc_pkg::*;
#(
    parameter int unsigned OPW        = 7,
    parameter int unsigned MAX_DIGITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             push,
`ifdef CALC_BACKSPACE_EN
    input  logic             pop,
    input  logic             recount,
`endif
    input  logic [KEY_W-1:0] digit,
    output logic [OPW-1:0]   value,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_nxt
);

    localparam int unsigned EW = OPW + 4;

    logic [OPW-1:0]   val_q, val_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [EW-1:0]    shifted;

    // value*10 + digit at extended width; digit limit keeps it within OPW
    assign shifted = EW'(val_q) * EW'(10) + EW'(digit);

    // Next-state selection
    always_comb begin
        val_nxt = val_q;
        cnt_nxt = cnt_q;
        if (clr) begin
            val_nxt = '0;
            cnt_nxt = '0;
        end else if (load) begin
            val_nxt = OPW'(digit);
            cnt_nxt = CNT_W'(1);
        end else if (push) begin
            if (cnt_q < CNT_W'(MAX_DIGITS)) begin
                val_nxt = OPW'(shifted);
                cnt_nxt = cnt_q + CNT_W'(1);
            end
`ifdef CALC_BACKSPACE_EN
        end else if (pop) begin
            if (cnt_q != '0) begin
                val_nxt = val_q / OPW'(10);
                cnt_nxt = cnt_q - CNT_W'(1);
            end
        end else if (recount) begin
            cnt_nxt = num_digits(32'(val_q));
`endif
        end
    end

    // Operand and count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= '0;
            cnt_q <= '0;
        end else begin
            val_q <= val_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    assign value = val_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/calc_operand_entry.sv
// Keypad front end of the calculator: builds two decimal operands from key
// strobes, holds the pending operation and commits op_code only on equals.
// Optional backspace key (15) is built when CALC_BACKSPACE_EN is defined.
// Ports:
//   clk, rst        clock, async active-high reset
//   key_code/valid  one-cycle key strobe from the debounced keypad
//   operand_a/b     calculator operand inputs
//   op_code         10 add, 11 sub, 12 mul, 13 idle
//   calc_go         one-cycle pulse on op_code commit
//   phase           0 ENTER_A, 1 ENTER_B, 2 SHOW
//   digit_cnt       digits entered into the current operand
module calc_operand_entry
    import calc_pkg::*;
#(
    parameter int unsigned OPW        = 7,
    parameter int unsigned MAX_DIGITS = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     key_code,
    input  logic           key_valid,
    output logic [OPW-1:0] operand_a,
    output logic [OPW-1:0] operand_b,
    output logic [3:0]     op_code,
    output logic           calc_go,
    output logic [1:0]     phase,
    output logic [1:0]     digit_cnt
);

    phase_t           phase_q, phase_nxt;
    logic [KEY_W-1:0] op_pending_q, op_pending_nxt;
    logic [KEY_W-1:0] op_code_q, op_code_nxt;
    logic             go_q, go_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;

    logic             a_clr, a_load, a_push;
    logic             b_clr, b_push;
    logic [CNT_W-1:0] a_cnt, b_cnt, a_cnt_nxt, b_cnt_nxt;
`ifdef CALC_BACKSPACE_EN
    logic             a_pop, a_recount, b_pop;
`endif

    logic is_digit, is_op;

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_op    = key_valid && ((key_code == KEY_ADD) || (key_code == KEY_SUB) ||
                                    (key_code == KEY_MUL));

    calc_digit_accum #(.OPW(OPW), .MAX_DIGITS(MAX_DIGITS)) u_acc_a (
        .clk     (clk),
        .rst     (rst),
        .clr     (a_clr),
        .load    (a_load),
        .push    (a_push),
`ifdef CALC_BACKSPACE_EN
        .pop     (a_pop),
        .recount (a_recount),
`endif
        .digit   (key_code),
        .value   (operand_a),
        .cnt     (a_cnt),
        .cnt_nxt (a_cnt_nxt)
    );

    calc_digit_accum #(.OPW(OPW), .MAX_DIGITS(MAX_DIGITS)) u_acc_b (
        .clk     (clk),
        .rst     (rst),
        .clr     (b_clr),
        .load    (1'b0),
        .push    (b_push),
`ifdef CALC_BACKSPACE_EN
        .pop     (b_pop),
        .recount (1'b0),
`endif
        .digit   (key_code),
        .value   (operand_b),
        .cnt     (b_cnt),
        .cnt_nxt (b_cnt_nxt)
    );

    // Key decode and phase sequencing
    always_comb begin
        phase_nxt      = phase_q;
        op_pending_nxt = op_pending_q;
        op_code_nxt    = op_code_q;
        go_nxt         = 1'b0;
        a_clr          = 1'b0;
        a_load         = 1'b0;
        a_push         = 1'b0;
        b_clr          = 1'b0;
        b_push         = 1'b0;
`ifdef CALC_BACKSPACE_EN
        a_pop          = 1'b0;
        a_recount      = 1'b0;
        b_pop          = 1'b0;
`endif
        if (key_valid && (key_code == KEY_CLR)) begin
            phase_nxt      = ENTER_A;
            op_pending_nxt = OP_IDLE;
            op_code_nxt    = OP_IDLE;
            a_clr          = 1'b1;
            b_clr          = 1'b1;
        end else if (key_valid) begin
            case (phase_q)
                ENTER_A: begin
                    if (is_digit) begin
                        a_push = 1'b1;
                    end else if (is_op) begin
                        op_pending_nxt = key_code;
                        b_clr          = 1'b1;
                        phase_nxt      = ENTER_B;
`ifdef CALC_BACKSPACE_EN
                    end else if (key_code == KEY_BS) begin
                        a_pop = 1'b1;
`endif
                    end
                end
                ENTER_B: begin
                    if (is_digit) begin
                        b_push = 1'b1;
                    end else if (is_op) begin
                        // operation can be changed until the first B digit
                        if (b_cnt == '0) begin
                            op_pending_nxt = key_code;
                        end
                    end else if (key_code == KEY_EQ) begin
                        if (b_cnt != '0) begin
                            op_code_nxt = op_pending_q;
                            go_nxt      = 1'b1;
                            phase_nxt   = SHOW;
                        end
`ifdef CALC_BACKSPACE_EN
                    end else if (key_code == KEY_BS) begin
                        if (b_cnt != '0) begin
                            b_pop = 1'b1;
                        end else begin
                            // back out of the operation into operand A
                            phase_nxt      = ENTER_A;
                            op_pending_nxt = OP_IDLE;
                            a_recount      = 1'b1;
                        end
`endif
                    end
                end
                SHOW: begin
                    // a digit after a result starts a fresh calculation
                    if (is_digit) begin
                        a_load         = 1'b1;
                        b_clr          = 1'b1;
                        op_code_nxt    = OP_IDLE;
                        op_pending_nxt = OP_IDLE;
                        phase_nxt      = ENTER_A;
                    end
                end
                default: begin
                    phase_nxt = ENTER_A;
                end
            endcase
        end

        // digit count tracks whichever operand is active after this edge
        cnt_nxt = (phase_nxt == ENTER_A) ? a_cnt_nxt : b_cnt_nxt;
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q      <= ENTER_A;
            op_pending_q <= OP_IDLE;
            op_code_q    <= OP_IDLE;
            go_q         <= 1'b0;
            cnt_q        <= '0;
        end else begin
            phase_q      <= phase_nxt;
            op_pending_q <= op_pending_nxt;
            op_code_q    <= op_code_nxt;
            go_q         <= go_nxt;
            cnt_q        <= cnt_nxt;
        end
    end

    assign op_code   = op_code_q;
    assign calc_go   = go_q;
    assign phase     = phase_q;
    assign digit_cnt = cnt_q;

    // a_cnt is only needed by the accumulator itself; the count output comes
    // from the registered next-state selection above
    logic unused_cnt;
    assign unused_cnt = ^a_cnt;

endmodule

// File: tb/tb_calc_operand_entry.sv
// Directed-vector bench for calc_operand_entry. Keys are driven on the
// falling edge and outputs are checked on the following falling edge.
module tb_calc_operand_entry;

    logic       clk;
    logic       rst;
    logic [3:0] key_code;
    logic       key_valid;
    logic [6:0] operand_a;
    logic [6:0] operand_b;
    logic [3:0] op_code;
    logic       calc_go;
    logic [1:0] phase;
    logic [1:0] digit_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    calc_operand_entry #(.OPW(7), .MAX_DIGITS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_code  (key_code),
        .key_valid (key_valid),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .op_code   (op_code),
        .calc_go   (calc_go),
        .phase     (phase),
        .digit_cnt (digit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one key strobe; returns on the falling edge after the sampling edge
    task automatic press(input int k);
        key_code  = 4'(k);
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".phase"}, 32'(phase), 0);
        check({tag, ".a"}, 32'(operand_a), 0);
        check({tag, ".b"}, 32'(operand_b), 0);
        check({tag, ".op"}, 32'(op_code), 13);
        check({tag, ".cnt"}, 32'(digit_cnt), 0);
        check({tag, ".go"}, 32'(calc_go), 0);
    endtask

    initial begin
        rst       = 1'b1;
        key_code  = 4'd0;
        key_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");

        // 42 + 17 =
        press(4);  check("t1.a4", 32'(operand_a), 4);  check("t1.cnt1", 32'(digit_cnt), 1);
        press(2);  check("t1.a42", 32'(operand_a), 42); check("t1.cnt2", 32'(digit_cnt), 2);
        @(negedge clk);
        check("t1.hold_a", 32'(operand_a), 42);
        press(10); check("t1.phB", 32'(phase), 1); check("t1.cntB", 32'(digit_cnt), 0);
        check("t1.op_entry", 32'(op_code), 13);
        press(1);
        press(7);  check("t1.b17", 32'(operand_b), 17);
        check("t1.go_pre", 32'(calc_go), 0);
        press(14);
        check("t1.op", 32'(op_code), 10);
        check("t1.go", 32'(calc_go), 1);
        check("t1.phase", 32'(phase), 2);
        check("t1.a", 32'(operand_a), 42);
        check("t1.b", 32'(operand_b), 17);
        @(negedge clk);
        check("t1.go_off", 32'(calc_go), 0);
        check("t1.op_hold", 32'(op_code), 10);

        // digit limit, then 99 * 99 =
        press(9);
        check("t2.a9", 32'(operand_a), 9);
        check("t2.b0", 32'(operand_b), 0);
        check("t2.op_idle", 32'(op_code), 13);
        check("t2.phA", 32'(phase), 0);
        check("t2.cnt1", 32'(digit_cnt), 1);
        press(9);
        press(9);
        check("t2.a99", 32'(operand_a), 99);
        check("t2.cnt2", 32'(digit_cnt), 2);
        press(12);
        press(9);
        press(9);
        press(9);
        check("t2.b99", 32'(operand_b), 99);
        press(14);
        check("t2.op", 32'(op_code), 12);
        check("t2.go", 32'(calc_go), 1);

        // operation replaced before first B digit
        press(5);
        press(11);
        press(10);
        press(3);
        press(14);
        check("t3.op_replace", 32'(op_code), 10);
        check("t3.b3", 32'(operand_b), 3);
        // operation after a B digit is ignored
        press(5);
        press(11);
        press(3);
        press(10);
        press(14);
        check("t3.op_keep", 32'(op_code), 11);
        check("t3.phase", 32'(phase), 2);

        // equals with no B digits ignored
        press(1);
        press(10);
        press(14);
        check("t4.phB", 32'(phase), 1);
        check("t4.op_idle", 32'(op_code), 13);
        check("t4.go0", 32'(calc_go), 0);
        press(2);
        press(14);
        check("t4.op", 32'(op_code), 10);
        check("t4.b2", 32'(operand_b), 2);
        check("t4.a1", 32'(operand_a), 1);

        // asynchronous reset mid-entry, checked before any rising edge
        press(7);
        press(10);
        check("t5.a7", 32'(operand_a), 7);
        #1 rst = 1'b1;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // clear key mid-entry
        press(3);
        press(10);
        press(5);
        check("t6.b5", 32'(operand_b), 5);
        press(13);
        check_reset_vals("clear");

        // backspace
        press(4);
        press(2);
        press(15);
`ifdef CALC_BACKSPACE_EN
        check("bs.a4", 32'(operand_a), 4);
        check("bs.cnt1", 32'(digit_cnt), 1);
        press(10);
        press(15);
        check("bs.phA", 32'(phase), 0);
        check("bs.cnt_restore", 32'(digit_cnt), 1);
        press(2);
        check("bs.a42", 32'(operand_a), 42);
        check("bs.cnt2", 32'(digit_cnt), 2);
`else
        check("bs.a42", 32'(operand_a), 42);
        check("bs.cnt2", 32'(digit_cnt), 2);
        press(10);
        press(15);
        check("bs.phB", 32'(phase), 1);
        check("bs.cnt0", 32'(digit_cnt), 0);
        check("bs.a_keep", 32'(operand_a), 42);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_operand_entry.md
Name: calc_operand_entry

Overview:
- Keypad-side front end of the calculator datapath.
- Consumes single-cycle key strobes from the debounced keypad, builds two decimal operands digit by digit and holds the selected operation.
- Drives the combinational calculator's two 7-bit operand inputs and its 4-bit operation code.
- Presents a stable operation code only after "equals", so the calculator never shows partial results.

Parameters:
- OPW, 7, operand width in bits; matches the calculator operand inputs.
- MAX_DIGITS, 2, maximum decimal digits per operand; 10^MAX_DIGITS-1 must not exceed 2^OPW-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_code  in  4  key value, valid only while key_valid=1.
- key_valid  in  1  one-cycle strobe per key press.
- operand_a  out  OPW  first operand, drives calculator In1.
- operand_b  out  OPW  second operand, drives calculator In2.
- op_code  out  4  operation to calculator: 10 add, 11 sub, 12 mul, 13 clear/idle.
- calc_go  out  1  one-cycle pulse when a new op_code is committed.
- phase  out  2  0 ENTER_A, 1 ENTER_B, 2 SHOW; used by the display mux.
- digit_cnt  out  2  digits entered into the current operand.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. rst assertion forces all state immediately, including mid-entry.
- Reset values:
  - phase=ENTER_A, operand_a=0, operand_b=0.
  - op_code=13, internal op_pending=13.
  - digit_cnt=0, calc_go=0.
- Timing: all outputs are registered and update on the clk edge that samples key_valid=1. Latency is 1 cycle. With key_valid=0, state holds and calc_go=0.
- Key classes:
  - 0-9: digit.
  - 10/11/12: operation.
  - 13: clear.
  - 14: equals.
  - 15: backspace (feature-dependent).
- ENTER_A:
  - Digit d with digit_cnt<MAX_DIGITS: operand_a <= operand_a*10+d; digit_cnt++.
  - Digit with digit_cnt==MAX_DIGITS: ignored (no wrap, no saturation change).
  - Operation key: op_pending <= key; operand_b <= 0; digit_cnt <= 0; phase <= ENTER_B. This is accepted even with zero digits (operand_a=0).
  - Equals: ignored.
- ENTER_B:
  - Digits accumulate into operand_b under the same rules as ENTER_A.
  - Operation key with digit_cnt==0: replaces op_pending. With digit_cnt>0: ignored.
  - Equals with digit_cnt>0: op_code <= op_pending; calc_go=1 for exactly one cycle; phase <= SHOW.
  - Equals with digit_cnt==0: ignored.
- SHOW:
  - Operands and op_code are held stable.
  - Digit d: operand_a <= d; operand_b <= 0; digit_cnt <= 1; op_code <= 13; op_pending <= 13; phase <= ENTER_A.
  - Operation and equals keys: ignored.
- Clear (13), any phase: same values as reset, synchronous.
- Arithmetic: multiply-by-10 plus add is evaluated at OPW+4 bits and truncated to OPW. The digit limit guarantees no truncation loss.
- op_code is never 10/11/12 outside SHOW. The calculator output is therefore 0 during entry.

Optional Feature:
- Macro: CALC_BACKSPACE_EN.
- Defined:
  - Key 15 in ENTER_A/ENTER_B with digit_cnt>0: current operand <= operand/10; digit_cnt--.
  - Key 15 in ENTER_B with digit_cnt==0: returns to ENTER_A with op_pending <= 13. digit_cnt is set to the number of decimal digits in operand_a (0 if operand_a=0).
  - Key 15 in SHOW: ignored.
- Undefined: key 15 is ignored in every phase; no divide logic is synthesised.

Decomposition:
- Shared package calc_pkg holds:
  - key code constants KEY_ADD=10, KEY_SUB=11, KEY_MUL=12, KEY_CLR=13, KEY_EQ=14, KEY_BS=15.
  - the phase enum (ENTER_A, ENTER_B, SHOW).
  - OP_IDLE=13.
- One natural sub-module, calc_digit_accum: per-operand register, digit counter, multiply-by-10 add, and optional divide-by-10. Instantiated twice (A, B) with load/clear/push/pop controls from the top FSM.

Test Plan:
- Reset then keys 4,2,A,1,7,E -> operand_a=42, operand_b=17, op_code=10; calc_go high exactly one cycle after E; phase=SHOW.
- Keys 9,9,9 -> operand_a=99, digit_cnt=2; the third 9 is ignored; then C,9,9,E -> op_code=12, operand_b=99.
- Keys 5,B,A,3,E -> op_pending replaced; op_code=10. Keys 5,B,3,A,E -> second operation ignored; op_code=11.
- Keys 1,A,E -> E ignored; phase stays ENTER_B; op_code stays 13. Then 2,E -> op_code=10, operand_b=2.
- Assert rst asynchronously while in ENTER_B with operand_a=7 -> outputs return to reset values without waiting for a clk edge. Key 13 mid-entry gives the same values on the next edge.
- With CALC_BACKSPACE_EN: 4,2,F -> operand_a=4, digit_cnt=1. Then A,F -> phase=ENTER_A, digit_cnt=1. Without the macro, F leaves all state unchanged.
